// File: rtl/julia_pixel_engine.sv
// Julia-set pixel engine: raster-scans the view and iterates z <= z^2 + c in Q4.12 for each pixel.
// Emits one (x, y, iteration count) record per pixel on a draw/draw_ready handshake.
module julia_pixel_engine #(
  parameter int H_RES    = 640,
  parameter int V_RES    = 480,
  parameter int MAX_ITER = 255,
  parameter int FRAC     = 12
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] c_re,
  input  logic [15:0] c_im,
  input  logic [15:0] re_start,
  input  logic [15:0] im_start,
  input  logic [15:0] step,
  output logic        draw,
  input  logic        draw_ready,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic [7:0]  i,
  output logic        busy,
  output logic        frame_done
);

  // state  | meaning
  // IDLE   | waiting for start
  // INIT   | load z from the current pixel coordinate
  // ITER   | one z^2 + c step per cycle until escape or cap
  // EMIT   | record valid, waiting for draw_ready
  // DONE   | one-cycle frame_done pulse
  typedef enum logic [2:0] {S_IDLE, S_INIT, S_ITER, S_EMIT, S_DONE} state_t;

  localparam logic [9:0]         X_LAST   = 10'(H_RES - 1);
  localparam logic [9:0]         Y_LAST   = 10'(V_RES - 1);
  localparam logic [7:0]         ITER_CAP = 8'(MAX_ITER);
  localparam logic signed [32:0] MAG_LIM  = 33'sd67108864;

  state_t state, state_nxt;

  logic signed [15:0] c_re_q, c_im_q, re0_q, step_q;
  logic signed [15:0] cur_re, cur_im, zr, zi;
  logic [7:0]         iter, i_q;
  logic [9:0]         x_q, y_q;

  logic signed [31:0] zr_sq, zi_sq, zr_zi;
  logic signed [32:0] mag, diff, twice;
  logic signed [17:0] re_sum, im_sum;
  logic               escape, last_pix, go, accept;

  function automatic logic signed [15:0] sat16(input logic signed [17:0] v);
    if (v > 18'sd32767)
      return 16'sh7FFF;
    else if (v < -18'sd32768)
      return 16'sh8000;
    else
      return v[15:0];
  endfunction

  assign zr_sq  = zr * zr;
  assign zi_sq  = zi * zi;
  assign zr_zi  = zr * zi;
  assign mag    = 33'(zr_sq) + 33'(zi_sq);
  assign diff   = 33'(zr_sq) - 33'(zi_sq);
  assign twice  = $signed({zr_zi, 1'b0});
  // Updates only happen while |z|^2 <= 4, so the shifted terms always fit in 18 bits.
  assign re_sum = 18'(diff >>> FRAC) + 18'(c_re_q);
  assign im_sum = 18'(twice >>> FRAC) + 18'(c_im_q);

  assign escape   = (mag > MAG_LIM) || (iter == ITER_CAP);
  assign last_pix = (x_q == X_LAST) && (y_q == Y_LAST);
  assign go       = (state == S_IDLE) && start && !abort;
  assign accept   = (state == S_EMIT) && draw_ready && !abort;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (go) state_nxt = S_INIT;
      S_INIT: state_nxt = S_ITER;
      S_ITER: if (escape) state_nxt = S_EMIT;
      S_EMIT: if (draw_ready) state_nxt = last_pix ? S_DONE : S_INIT;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    // abort beats everything, including a same-cycle accept
    if (abort)
      state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      c_re_q <= '0;
      c_im_q <= '0;
      re0_q  <= '0;
      step_q <= '0;
      cur_re <= '0;
      cur_im <= '0;
      zr     <= '0;
      zi     <= '0;
      iter   <= '0;
      i_q    <= '0;
      x_q    <= '0;
      y_q    <= '0;
    end else begin
      if (go) begin
        c_re_q <= c_re;
        c_im_q <= c_im;
        re0_q  <= re_start;
        step_q <= step;
        cur_re <= re_start;
        cur_im <= im_start;
        x_q    <= '0;
        y_q    <= '0;
      end
      if (state == S_INIT) begin
        zr   <= cur_re;
        zi   <= cur_im;
        iter <= '0;
      end
      if (state == S_ITER) begin
        if (escape) begin
          i_q <= iter;
        end else begin
          zr   <= sat16(re_sum);
          zi   <= sat16(im_sum);
          iter <= iter + 8'd1;
        end
      end
      if (accept && !last_pix) begin
        if (x_q == X_LAST) begin
          x_q    <= '0;
          y_q    <= y_q + 10'd1;
          cur_re <= re0_q;
          cur_im <= cur_im - step_q;
        end else begin
          x_q    <= x_q + 10'd1;
          cur_re <= cur_re + step_q;
        end
      end
    end
  end

  assign draw       = (state == S_EMIT);
  assign busy       = (state != S_IDLE);
  assign frame_done = (state == S_DONE);
  assign x          = x_q;
  assign y          = y_q;
  assign i          = i_q;

endmodule

// File: tb/tb_julia_pixel_engine.sv
// Self-checking bench for julia_pixel_engine on a 4x3 view with a 64-iteration cap.
// Expected counts come from a plain-integer Julia iteration model.
module tb_julia_pixel_engine;
  localparam int H   = 4;
  localparam int V   = 3;
  localparam int MAX = 64;

  logic        clk = 1'b0;
  logic        reset_n, start, abort, draw_ready;
  logic [15:0] c_re, c_im, re_start, im_start, step;
  logic        draw, busy, frame_done;
  logic [9:0]  x, y;
  logic [7:0]  i;

  int n_cmp = 0;
  int n_bad = 0;

  julia_pixel_engine #(.H_RES(H), .V_RES(V), .MAX_ITER(MAX), .FRAC(12)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .c_re(c_re), .c_im(c_im), .re_start(re_start), .im_start(im_start), .step(step),
    .draw(draw), .draw_ready(draw_ready), .x(x), .y(y), .i(i),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint to_s16(input longint v);
    logic [15:0] t;
    t = v[15:0];
    return longint'($signed(t));
  endfunction

  function automatic longint clamp16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Escape-time count for one point, straight from the fixed-point definition.
  function automatic int model_iter(input longint re, input longint im,
                                    input longint cr, input longint ci);
    longint zr, zi, nr, ni;
    zr = re;
    zi = im;
    for (int n = 0; n <= MAX; n++) begin
      if (zr * zr + zi * zi > 64'sd67108864 || n == MAX) return n;
      nr = ((zr * zr - zi * zi) >>> 12) + cr;
      ni = ((2 * zr * zi) >>> 12) + ci;
      zr = clamp16(nr);
      zi = clamp16(ni);
    end
    return MAX;
  endfunction

  task automatic start_frame(input logic [15:0] cr, input logic [15:0] ci,
                             input logic [15:0] rs, input logic [15:0] is,
                             input logic [15:0] st);
    @(negedge clk);
    c_re = cr; c_im = ci; re_start = rs; im_start = is; step = st;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  task automatic wait_draw(output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      cyc++;
      if (draw) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("draw_timeout", 0, 1);
  endtask

  task automatic take_record(input int ex, input int ey, input int ei, input int hold, input bit last);
    int          cyc;
    bit          ok;
    logic [27:0] exp_rec;
    wait_draw(cyc, ok);
    if (!ok) return;
    exp_rec = {10'(ex), 10'(ey), 8'(ei)};
    check("latency", cyc, ei + 2);
    check("x", x, ex);
    check("y", y, ey);
    check("i", i, ei);
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      check("hold_draw", draw, 1);
      check("hold_record", {x, y, i}, exp_rec);
    end
    draw_ready = 1'b1;
    @(negedge clk);
    draw_ready = 1'b0;
    check("draw_fall", draw, 0);
    check("frame_done_pulse", frame_done, last);
    if (last) begin
      @(negedge clk);
      check("busy_end", busy, 0);
      check("frame_done_end", frame_done, 0);
    end
  endtask

  task automatic abort_now();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_draw", draw, 0);
  endtask

  task automatic run_frame(input logic [15:0] cr, input logic [15:0] ci,
                           input logic [15:0] rs, input logic [15:0] is,
                           input logic [15:0] st, input bit rand_hold);
    longint re, im;
    int     ei;
    start_frame(cr, ci, rs, is, st);
    for (int py = 0; py < V; py++) begin
      for (int px = 0; px < H; px++) begin
        re = to_s16(to_s16(rs) + px * to_s16(st));
        im = to_s16(to_s16(is) - py * to_s16(st));
        ei = model_iter(re, im, to_s16(cr), to_s16(ci));
        take_record(px, py, ei, rand_hold ? int'($urandom_range(0, 3)) : 0,
                    (px == H - 1) && (py == V - 1));
      end
    end
  endtask

  initial begin
    bit seen;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; draw_ready = 1'b0;
    c_re = '0; c_im = '0; re_start = '0; im_start = '0; step = '0;
    repeat (3) @(negedge clk);
    check("rst_draw", draw, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_x", x, 0);
    check("rst_y", y, 0);
    check("rst_i", i, 0);
    reset_n = 1'b1;

    // first-pixel escape behaviour, then abort out of the frame
    start_frame(16'h0000, 16'h0000, 16'h3000, 16'h0000, 16'h0000);
    take_record(0, 0, 0, 0, 1'b0);
    abort_now();
    start_frame(16'h0000, 16'h0000, 16'h1800, 16'h0000, 16'h0000);
    take_record(0, 0, 1, 0, 1'b0);
    abort_now();
    start_frame(16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    take_record(0, 0, MAX, 10, 1'b0);
    abort_now();

    // start and abort together in IDLE must not launch a frame
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("start_abort_busy", busy, 0);
    repeat (3) @(negedge clk);
    check("start_abort_draw", draw, 0);

    run_frame(16'h0000, 16'h0000, 16'h1000, 16'h0100, 16'h0100, 1'b0);

    for (int f = 0; f < 4; f++) begin
      run_frame(16'($urandom_range(0, 16'h2000)) - 16'h1000,
                16'($urandom_range(0, 16'h2000)) - 16'h1000,
                16'($urandom_range(0, 16'h2000)) - 16'h2000,
                16'($urandom_range(0, 16'h1800)),
                16'($urandom_range(16'h0080, 16'h0600)), 1'b1);
    end

    // abort during ITER of pixel 5
    start_frame(16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    for (int k = 0; k < 5; k++) take_record(k % H, k / H, MAX, 0, 1'b0);
    repeat (10) @(negedge clk);
    abort_now();
    seen = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (draw) seen = 1'b1;
    end
    check("no_draw_after_abort", seen, 0);
    start_frame(16'h0000, 16'h0000, 16'h3000, 16'h0000, 16'h0000);
    take_record(0, 0, 0, 0, 1'b0);
    abort_now();

    // asynchronous reset mid-frame
    start_frame(16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_x", x, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
